// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath and its arbiter front end.
//   OP_*        : 3-bit ALU opcodes (101..111 are unassigned and yield zero)
//   arb_state_t : arbiter FSM states (IDLE, EXEC, RESP)
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu
// Purely combinational 8-bit ALU.
//   a, b      in  8 : operands
//   op        in  3 : opcode (see alu_pkg)
//   result    out 8 : operation result
//   carry_out out 1 : carry/borrow of the upper nibble only
//   zero      out 1 : result == 0
// Unassigned opcodes return result 0x00 with carry 0 (and therefore zero 1).
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       carry_out,
    output logic       zero
);

    // The carry flag is derived from the upper nibbles alone, ignoring any
    // carry or borrow rippling up from the lower nibble.
    logic [4:0] hi_sum;

    assign hi_sum = {1'b0, a[7:4]} + {1'b0, b[7:4]};

    always_comb begin
        result    = 8'h00;
        carry_out = 1'b0;
        case (op)
            OP_ADD: begin
                result    = a + b;
                carry_out = hi_sum[4];
            end
            OP_SUB: begin
                result    = a - b;
                carry_out = (a[7:4] < b[7:4]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: result = 8'h00;
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter/sequencer sharing one alu between NUM_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (at most one ready high)
//   req_a, req_b, req_op: packed per-requester operands and opcode
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester index owning the response
//   rsp_result/carry/zero : registered alu outputs
//   busy                : high whenever the FSM is not IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 busy
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [7:0]      cur_a_q, cur_a_d;
    logic [7:0]      cur_b_q, cur_b_d;
    logic [2:0]      cur_op_q, cur_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_result_q, rsp_result_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic [ID_W-1:0] grant;
    logic [7:0]      alu_result;
    logic            alu_carry;
    logic            alu_zero;

    // Search upward from the slot after the last winner, wrapping around.
    // Only meaningful when at least one valid bit is set.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant = rr_pick(req_valid, last_grant_q);

    alu u_alu (
        .a         (cur_a_q),
        .b         (cur_b_q),
        .op        (cur_op_q),
        .result    (alu_result),
        .carry_out (alu_carry),
        .zero      (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cur_id_q     <= '0;
            cur_a_q      <= 8'h00;
            cur_b_q      <= 8'h00;
            cur_op_q     <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 8'h00;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            cur_a_q      <= cur_a_d;
            cur_b_q      <= cur_b_d;
            cur_op_q     <= cur_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        cur_a_d      = cur_a_q;
        cur_b_d      = cur_b_q;
        cur_op_d     = cur_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    cur_a_d      = req_a[int'(grant)*8 +: 8];
                    cur_b_d      = req_b[int'(grant)*8 +: 8];
                    cur_op_d     = req_op[int'(grant)*3 +: 3];
                    cur_id_d     = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = cur_id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_ready depends only on state and req_valid, never on rsp_ready.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && |req_valid) begin
            req_ready[grant] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter with four requesters. A predictor
// process tracks the round-robin order and pushes expected responses; a
// monitor process pops them when the DUT presents a response.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic [3*N-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [7:0]     rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;
    logic           busy;

    typedef struct {
        int         id;
        logic [7:0] result;
        logic       carry;
        logic       zero;
        int         acc_cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] refill;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one operation, from the opcode rules.
    function automatic exp_t model_op(int id, logic [7:0] a, logic [7:0] b, logic [2:0] op, int cyc);
        exp_t e;
        int   ai = int'(a);
        int   bi = int'(b);
        int   r  = 0;
        logic c  = 1'b0;
        case (op)
            OP_ADD: begin r = (ai + bi) % 256;       c = ((ai / 16) + (bi / 16)) > 15; end
            OP_SUB: begin r = (ai - bi + 256) % 256; c = (ai / 16) < (bi / 16);        end
            OP_AND: r = ai & bi;
            OP_OR:  r = ai | bi;
            OP_NOT: r = 255 - ai;
            default: r = 0;
        endcase
        e.id      = id;
        e.result  = 8'(r);
        e.carry   = c;
        e.zero    = (r == 0);
        e.acc_cyc = cyc;
        return e;
    endfunction

    function automatic int model_pick(logic [N-1:0] v, int last);
        logic [IW-1:0] j;
        for (int k = 1; k <= N; k++) begin
            j = IW'((last + k) % N);
            if (v[j]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Predictor: checks grants and busy, enqueues expected responses.
    initial begin : predictor
        bit idle = 1'b1;
        int last = N - 1;
        int cyc  = 0;
        int g;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                idle = 1'b1;
                last = N - 1;
                check_output("reset_ready", req_ready, 0);
                check_output("reset_busy", busy, 0);
            end else begin
                check_output("busy", busy, !idle);
                if (idle && req_valid != '0) begin
                    g = model_pick(req_valid, last);
                    check_output("grant", req_ready, 1 << g);
                    sb_q.push_back(model_op(g, req_a[8*g +: 8], req_b[8*g +: 8], req_op[3*g +: 3], cyc));
                    last = g;
                    idle = 1'b0;
                end else begin
                    check_output("ready_low", req_ready, 0);
                end
                if (rsp_valid && rsp_ready) idle = 1'b1;
            end
        end
    end

    // Monitor: compares every presented response against the queue front.
    initial begin : monitor
        int   cyc  = 0;
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb_q.delete();
                prev = 1'b0;
                check_output("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero}, 0);
            end else begin
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL rsp_unexpected: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
                    end else begin
                        e = sb_q[0];
                        if (!prev) check_output("latency", cyc, e.acc_cyc + 2);
                        check_output("rsp_id", rsp_id, e.id);
                        check_output("rsp_result", rsp_result, e.result);
                        check_output("rsp_carry", rsp_carry, e.carry);
                        check_output("rsp_zero", rsp_zero, e.zero);
                        if (rsp_ready) void'(sb_q.pop_front());
                    end
                end
                prev = rsp_valid && !rsp_ready;
            end
        end
    end

    task automatic apply_stimulus(int i, logic [7:0] a, logic [7:0] b, logic [2:0] op);
        logic [IW-1:0] ii;
        ii = IW'(i);
        req_valid[ii]  = 1'b1;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_op[3*i +: 3] = op;
    endtask

    // One clock: note handshakes, then retire or refill granted requesters.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[IW'(i)]) begin
                if (refill[IW'(i)]) apply_stimulus(i, 8'($urandom), 8'($urandom), 3'($urandom));
                else req_valid[IW'(i)] = 1'b0;
            end
        end
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        refill    = '0;
        apply_reset();

        rsp_ready = 1'b1;
        apply_stimulus(0, 8'h12, 8'h34, OP_ADD);
        steps(5);

        apply_stimulus(1, 8'hF0, 8'h10, OP_ADD);
        steps(4);
        apply_stimulus(1, 8'h35, 8'h12, OP_SUB);
        steps(4);

        apply_reset();
        refill = '1;
        for (int i = 0; i < N; i++) apply_stimulus(i, 8'(16 * i + 1), 8'($urandom), 3'($urandom_range(0, 4)));
        steps(16);
        refill    = '0;
        req_valid = '0;
        steps(4);

        rsp_ready = 1'b0;
        apply_stimulus(2, 8'hF0, 8'h3C, OP_AND);
        step();
        apply_stimulus(3, 8'h07, 8'h01, OP_OR);
        steps(6);
        rsp_ready = 1'b1;
        steps(6);

        apply_stimulus(0, 8'hAA, 8'h55, 3'b111);
        steps(4);

        apply_stimulus(1, 8'h11, 8'h22, OP_ADD);
        step();
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        apply_stimulus(0, 8'h01, 8'hFF, OP_ADD);
        apply_stimulus(2, 8'h0F, 8'h0F, OP_SUB);
        steps(10);

        for (int t = 0; t < 300; t++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[IW'(i)] && $urandom_range(0, 2) == 0)
                    apply_stimulus(i, 8'($urandom), 8'($urandom), 3'($urandom));
            end
            step();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        steps(8);
        check_output("queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
